// File: rtl/vram_write_fifo.sv
// vram_write_fifo
// ---------------------------------------------------------------------------
// Single-clock (100 MHz) write FIFO that buffers CPU pixel writes headed for
// VRAM. The CPU writes at up to one entry per cycle. The SRAM arbiter drains
// entries through a pop port whose outputs are registered: the head entry
// appears on rd_addr/rd_data the cycle after an accepted pop, and it holds
// there until the next accepted pop.
//
// Ports:
//   clk100       in   100 MHz clock shared by the CPU and the arbiter
//   reset_n      in   asynchronous active-low reset
//   cpu_addr     in   [16:0] VRAM byte address of the CPU write
//   cpu_data     in   [7:0]  pixel data of the CPU write
//   cpu_we       in   write request, one entry per asserted cycle
//   cpu_ready    out  a write this cycle will be accepted (!full)
//   rd_en        in   pop request from the arbiter
//   rd_addr      out  [16:0] registered head address after an accepted pop
//   rd_data      out  [7:0]  registered head data after an accepted pop
//   empty        out  no stored entries
//   full         out  2^DEPTH_LOG2 entries stored
//   almost_full  out  free entries <= ALMOST_FULL_MARGIN
//   level        out  [DEPTH_LOG2:0] current entry count
//   overflow     out  sticky: a write arrived while full and was dropped
//   overflow_clr in   clears overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module vram_write_fifo #(
    parameter int DEPTH_LOG2         = 5,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                  clk100,
    input  logic                  reset_n,
    input  logic [16:0]           cpu_addr,
    input  logic [7:0]            cpu_data,
    input  logic                  cpu_we,
    output logic                  cpu_ready,
    input  logic                  rd_en,
    output logic [16:0]           rd_addr,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_MARGIN = (DEPTH_LOG2 + 1)'(ALMOST_FULL_MARGIN);

    // Each entry is {addr[16:0], data[7:0]}.
    logic [24:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;

    logic                    wr_ok;
    logic                    rd_ok;
    logic [DEPTH_LOG2:0]     level_nxt;
    logic [DEPTH_LOG2:0]     free_nxt;

    // Full rejects a write even when a pop frees a slot at the same edge,
    // and an empty FIFO ignores rd_en even if a write lands at that edge.
    assign wr_ok     = cpu_we && !full;
    assign rd_ok     = rd_en && !empty;
    assign cpu_ready = !full;

    always_comb begin
        level_nxt = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    assign free_nxt = DEPTH_L - level_nxt;

    // Storage array: contents are never reset, only the pointers are.
    always_ff @(posedge clk100) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {cpu_addr, cpu_data};
        end
    end

    // Pointers, level and flags. Flags are computed from the next-state level
    // so they are registered yet coincide with the new level value.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level       <= level_nxt;
            empty       <= (level_nxt == '0);
            full        <= (level_nxt == DEPTH_L);
            almost_full <= (free_nxt <= AF_MARGIN);
        end
    end

    // Registered pop outputs: load the head on an accepted pop, else hold.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr <= '0;
            rd_data <= '0;
        end else if (rd_ok) begin
            rd_addr <= mem[rd_ptr][24:8];
            rd_data <= mem[rd_ptr][7:0];
        end
    end

    // Sticky overflow: a dropped write takes priority over a clear.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (cpu_we && full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_write_fifo.sv
module tb_vram_write_fifo;

    localparam int DEPTH = 32;

    logic        clk100;
    logic        reset_n;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic        cpu_ready;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [5:0]  level;
    logic        overflow;
    logic        overflow_clr;

    vram_write_fifo #(
        .DEPTH_LOG2         (5),
        .ALMOST_FULL_MARGIN (4)
    ) dut (
        .clk100       (clk100),
        .reset_n      (reset_n),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_we       (cpu_we),
        .cpu_ready    (cpu_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue of {addr, data} entries plus the last
    // popped values and the sticky overflow bit.
    logic [24:0] mq[$];
    logic [16:0] m_addr;
    logic [7:0]  m_data;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = mq.size();
        chk({ctx, ".level"},       32'(level),       32'(n));
        chk({ctx, ".empty"},       32'(empty),       32'(n == 0));
        chk({ctx, ".full"},        32'(full),        32'(n == DEPTH));
        chk({ctx, ".almost_full"}, 32'(almost_full), 32'((DEPTH - n) <= 4));
        chk({ctx, ".cpu_ready"},   32'(cpu_ready),   32'(n != DEPTH));
        chk({ctx, ".overflow"},    32'(overflow),    32'(m_ovf));
        chk({ctx, ".rd_addr"},     32'(rd_addr),     32'(m_addr));
        chk({ctx, ".rd_data"},     32'(rd_data),     32'(m_data));
    endtask

    // One clock of traffic: drive, take the edge, advance the model from its
    // pre-edge state, then compare just after the edge.
    task automatic step(input string ctx, input bit we, input logic [16:0] a,
                        input logic [7:0] d, input bit re, input bit clr);
        bit          wacc;
        bit          racc;
        logic [24:0] e;
        cpu_we       = we;
        cpu_addr     = a;
        cpu_data     = d;
        rd_en        = re;
        overflow_clr = clr;
        @(posedge clk100);
        wacc = we && (mq.size() < DEPTH);
        racc = re && (mq.size() > 0);
        if (we && mq.size() == DEPTH) m_ovf = 1'b1;
        else if (clr)                 m_ovf = 1'b0;
        if (racc) begin
            e      = mq.pop_front();
            m_addr = e[24:8];
            m_data = e[7:0];
        end
        if (wacc) mq.push_back({a, d});
        #1;
        check_all(ctx);
    endtask

    task automatic idle_inputs();
        cpu_we       = 1'b0;
        cpu_addr     = '0;
        cpu_data     = '0;
        rd_en        = 1'b0;
        overflow_clr = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_addr = '0;
        m_data = '0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset_n = 1'b0;

        // Reset state
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Single write then pop
        step("single_wr", 1'b1, 17'h1ABCD, 8'h5A, 1'b0, 1'b0);
        chk("single_wr.not_empty", 32'(empty), 32'd0);
        step("single_idle", 1'b0, '0, '0, 1'b0, 1'b0);
        step("single_pop", 1'b0, '0, '0, 1'b1, 1'b0);
        chk("single_pop.addr", 32'(rd_addr), 32'h1ABCD);
        chk("single_pop.data", 32'(rd_data), 32'h5A);
        chk("single_pop.empty", 32'(empty), 32'd1);

        // Pop on empty is ignored and outputs hold
        step("pop_empty", 1'b0, '0, '0, 1'b1, 1'b0);

        // Fill to full with addr = data = i
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1'b1, 17'(i), 8'(i), 1'b0, 1'b0);
        end
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.cpu_ready", 32'(cpu_ready), 32'd0);

        // Write while full is dropped
        step("drop", 1'b1, 17'h100, 8'h00, 1'b0, 1'b0);
        chk("drop.overflow", 32'(overflow), 32'd1);
        chk("drop.level", 32'(level), 32'd32);

        // Full with simultaneous write and pop
        step("full_wr_pop", 1'b1, 17'h0ABC, 8'hEE, 1'b1, 1'b0);
        chk("full_wr_pop.addr", 32'(rd_addr), 32'h0);
        chk("full_wr_pop.level", 32'(level), 32'd31);
        step("after_full_wr", 1'b1, 17'h1FF00, 8'hC3, 1'b0, 1'b0);
        chk("after_full_wr.level", 32'(level), 32'd32);

        // Drain: 1..31 then the new entry, across pointer wrap
        for (int i = 1; i <= 31; i++) begin
            step("drain", 1'b0, '0, '0, 1'b1, 1'b0);
            chk("drain.seq", 32'(rd_addr), 32'(i));
        end
        step("drain_last", 1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_last.addr", 32'(rd_addr), 32'h1FF00);
        chk("drain_last.data", 32'(rd_data), 32'hC3);

        // Write every cycle, pop every third cycle, from level 0
        for (int i = 0; i < 45; i++) begin
            step("traffic", 1'b1, 17'($urandom), 8'($urandom), (i % 3) == 2, 1'b0);
        end
        chk("traffic.level", 32'(level), 32'd30);

        // Randomized mixed traffic
        for (int i = 0; i < 400; i++) begin
            step("random", $urandom_range(0, 3) != 0, 17'($urandom), 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        // Overflow clear vs a same-cycle drop
        for (int i = 0; i < 40 && mq.size() < DEPTH; i++) begin
            step("refill", 1'b1, 17'($urandom), 8'($urandom), 1'b0, 1'b0);
        end
        step("ovf_set_clr", 1'b1, 17'h00F, 8'h0F, 1'b0, 1'b1);
        chk("ovf_set_clr.overflow", 32'(overflow), 32'd1);
        step("ovf_clr", 1'b0, '0, '0, 1'b0, 1'b1);
        chk("ovf_clr.overflow", 32'(overflow), 32'd0);

        // Reset mid-stream with 10 entries queued
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            step("predrain", 1'b0, '0, '0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            step("prequeue", 1'b1, 17'(17'h10000 + i), 8'(8'hA0 + i), 1'b0, 1'b0);
        end
        chk("prequeue.level", 32'(level), 32'd10);
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        chk("midreset.empty", 32'(empty), 32'd1);
        chk("midreset.rd_addr", 32'(rd_addr), 32'd0);
        #2;
        reset_n = 1'b1;
        step("fresh_wr", 1'b1, 17'h0F0F0, 8'h99, 1'b0, 1'b0);
        step("fresh_pop", 1'b0, '0, '0, 1'b1, 1'b0);
        chk("fresh_pop.addr", 32'(rd_addr), 32'h0F0F0);
        chk("fresh_pop.data", 32'(rd_data), 32'h99);
        chk("fresh_pop.empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
